instr_prefetch_queue: RTL and testbench

INSTR_PREFETCH_QUEUE -- requirements
Module: instr_prefetch_queue

---
 rtl/instr_prefetch_queue.sv | 134 +++++++++++++
 tb/tb_instr_prefetch_queue.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/instr_prefetch_queue.sv
// Instruction prefetch queue: fetches sequential words from instruction memory
// into a small FIFO feeding decode, with branch-redirect flush and halt support.
module instr_prefetch_queue #(
  parameter int unsigned DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0
) (
  input  logic        clk1,
  input  logic        reset,
  output logic        imem_req,
  output logic [9:0]  imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  input  logic        halt,
  output logic        if_valid,
  output logic [31:0] if_ir,
  output logic [31:0] if_npc,
  input  logic        id_ready
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT,
    ST_DROP
  } state_e;

  state_e             state_q, state_d;
  logic [31:0]        pc_q, pc_d;
  logic [9:0]         addr_q, addr_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;

  logic [31:0]        ir_mem  [DEPTH];
  logic [31:0]        npc_mem [DEPTH];

  logic               enq;
  logic               deq;
  logic               issue;
  logic [CNT_W-1:0]   count_nom;
  logic [31:0]        pc_inc;

  // In WAIT the pc register still holds the address of the outstanding fetch.
  assign pc_inc = pc_q + 32'd1;

  always_comb begin
    // NOTE: every variable assigned here gets a default first so no latch is inferred.
    state_d   = state_q;
    pc_d      = pc_q;
    addr_d    = addr_q;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;

    enq       = (state_q == ST_WAIT) && imem_ack && !redirect;
    deq       = (count_q != '0) && id_ready && !redirect;
    count_nom = count_q + CNT_W'(enq) - CNT_W'(deq);
    issue     = !halt && !redirect && (count_nom < CNT_W'(DEPTH));
    count_d   = count_nom;

    if (redirect) begin
      pc_d     = redirect_pc;
      count_d  = '0;
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      // An ack arriving with the redirect completes the fetch; otherwise its data is still owed.
      if (state_q != ST_IDLE) begin
        state_d = imem_ack ? ST_IDLE : ST_DROP;
      end
    end else begin
      if (enq) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (deq) rd_ptr_d = rd_ptr_q + PTR_W'(1);
      unique case (state_q)
        ST_IDLE: begin
          if (issue) begin
            state_d = ST_WAIT;
            addr_d  = pc_q[9:0];
          end
        end
        ST_WAIT: begin
          if (imem_ack) begin
            pc_d = pc_inc;
            if (issue) begin
              addr_d = pc_inc[9:0];
            end else begin
              state_d = ST_IDLE;
            end
          end
        end
        ST_DROP: begin
          if (imem_ack) state_d = ST_IDLE;
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk1) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      pc_q     <= RESET_PC;
      addr_q   <= '0;
      count_q  <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so all registers update together.
      state_q  <= state_d;
      pc_q     <= pc_d;
      addr_q   <= addr_d;
      count_q  <= count_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // NOTE: the entry storage is not reset; the count gates every read, so stale contents are never visible.
  always_ff @(posedge clk1) begin
    if (enq && !reset) begin
      ir_mem[wr_ptr_q]  <= imem_rdata;
      npc_mem[wr_ptr_q] <= pc_inc;
    end
  end

  assign imem_req  = (state_q != ST_IDLE);
  assign imem_addr = addr_q;
  assign if_valid  = (count_q != '0);
  assign if_ir     = if_valid ? ir_mem[rd_ptr_q]  : 32'h0;
  assign if_npc    = if_valid ? npc_mem[rd_ptr_q] : 32'h0;

endmodule

// File: tb/tb_instr_prefetch_queue.sv
// Directed self-checking bench for instr_prefetch_queue: streaming, full queue,
// redirect during/with an ack, halt, reset mid-fetch and pc wrap.
module tb_instr_prefetch_queue;

  logic        clk1 = 1'b0;
  logic        reset;
  logic        imem_req;
  logic [9:0]  imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        halt;
  logic        if_valid;
  logic [31:0] if_ir;
  logic [31:0] if_npc;
  logic        id_ready;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk1 = ~clk1;

  // Memory model: each word is tagged with its own address.
  always_comb imem_rdata = 32'hA000_0000 + {22'd0, imem_addr};

  instr_prefetch_queue dut (
    .clk1        (clk1),
    .reset       (reset),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_ack    (imem_ack),
    .imem_rdata  (imem_rdata),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .halt        (halt),
    .if_valid    (if_valid),
    .if_ir       (if_ir),
    .if_npc      (if_npc),
    .id_ready    (id_ready)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk1);
    #1;
  endtask

  task automatic do_reset();
    reset       = 1'b1;
    imem_ack    = 1'b0;
    redirect    = 1'b0;
    redirect_pc = 32'h0;
    halt        = 1'b0;
    id_ready    = 1'b0;
    tick();
    tick();
    check("rst_req",   {31'd0, imem_req}, 32'd0);
    check("rst_addr",  {22'd0, imem_addr}, 32'd0);
    check("rst_valid", {31'd0, if_valid}, 32'd0);
    check("rst_ir",    if_ir, 32'd0);
    check("rst_npc",   if_npc, 32'd0);
    reset = 1'b0;
  endtask

  initial begin
    // Back-to-back streaming, one instruction per cycle.
    do_reset();
    imem_ack = 1'b1;
    id_ready = 1'b1;
    tick();
    check("s_req0",  {31'd0, imem_req}, 32'd1);
    check("s_addr0", {22'd0, imem_addr}, 32'd0);
    check("s_val0",  {31'd0, if_valid}, 32'd0);
    for (int i = 1; i <= 6; i++) begin
      tick();
      check("s_addr", {22'd0, imem_addr}, i);
      check("s_val",  {31'd0, if_valid}, 32'd1);
      check("s_ir",   if_ir, 32'hA000_0000 + i - 1);
      check("s_npc",  if_npc, i);
    end

    // Decode stalled: queue fills to DEPTH, then drains in order.
    do_reset();
    imem_ack = 1'b1;
    repeat (5) tick();
    check("f_req_full", {31'd0, imem_req}, 32'd0);
    check("f_val_full", {31'd0, if_valid}, 32'd1);
    tick();
    check("f_req_hold", {31'd0, imem_req}, 32'd0);
    check("f_ir0",  if_ir, 32'hA000_0000);
    check("f_npc0", if_npc, 32'd1);
    id_ready = 1'b1;
    tick();
    check("f_ir1",   if_ir, 32'hA000_0001);
    check("f_req4",  {31'd0, imem_req}, 32'd1);
    check("f_addr4", {22'd0, imem_addr}, 32'd4);
    tick();
    check("f_ir2",   if_ir, 32'hA000_0002);
    check("f_addr5", {22'd0, imem_addr}, 32'd5);
    tick();
    check("f_ir3",   if_ir, 32'hA000_0003);
    tick();
    check("f_ir4",   if_ir, 32'hA000_0004);
    check("f_npc4",  if_npc, 32'd5);

    // Redirect while waiting on address 5 with the ack held off.
    do_reset();
    imem_ack = 1'b1;
    id_ready = 1'b1;
    repeat (6) tick();
    check("r_addr5", {22'd0, imem_addr}, 32'd5);
    imem_ack    = 1'b0;
    redirect    = 1'b1;
    redirect_pc = 32'h40;
    tick();
    redirect = 1'b0;
    check("r_drop_req",  {31'd0, imem_req}, 32'd1);
    check("r_drop_addr", {22'd0, imem_addr}, 32'd5);
    check("r_flush",     {31'd0, if_valid}, 32'd0);
    tick();
    tick();
    check("r_drop_hold", {22'd0, imem_addr}, 32'd5);
    imem_ack = 1'b1;
    tick();
    check("r_stale_req", {31'd0, imem_req}, 32'd0);
    check("r_stale_val", {31'd0, if_valid}, 32'd0);
    tick();
    check("r_new_addr", {22'd0, imem_addr}, 32'h40);
    check("r_new_req",  {31'd0, imem_req}, 32'd1);
    tick();
    check("r_new_val", {31'd0, if_valid}, 32'd1);
    check("r_new_ir",  if_ir, 32'hA000_0040);
    check("r_new_npc", if_npc, 32'h41);

    // Redirect coincident with ack and dequeue.
    do_reset();
    imem_ack = 1'b1;
    id_ready = 1'b1;
    repeat (3) tick();
    check("c_pre_val", {31'd0, if_valid}, 32'd1);
    redirect    = 1'b1;
    redirect_pc = 32'h100;
    tick();
    redirect = 1'b0;
    check("c_val",  {31'd0, if_valid}, 32'd0);
    check("c_req",  {31'd0, imem_req}, 32'd0);
    tick();
    check("c_addr", {22'd0, imem_addr}, 32'h100);
    check("c_val2", {31'd0, if_valid}, 32'd0);
    tick();
    check("c_ir",   if_ir, 32'hA000_0100);
    check("c_npc",  if_npc, 32'h101);

    // Halt during an outstanding fetch.
    do_reset();
    id_ready = 1'b1;
    tick();
    halt = 1'b1;
    tick();
    check("h_req_wait", {31'd0, imem_req}, 32'd1);
    imem_ack = 1'b1;
    tick();
    check("h_req_off", {31'd0, imem_req}, 32'd0);
    check("h_ir",      if_ir, 32'hA000_0000);
    tick();
    check("h_empty",   {31'd0, if_valid}, 32'd0);
    tick();
    check("h_no_req",  {31'd0, imem_req}, 32'd0);
    halt = 1'b0;
    tick();
    check("h_resume_req",  {31'd0, imem_req}, 32'd1);
    check("h_resume_addr", {22'd0, imem_addr}, 32'd1);

    // Reset mid-fetch with two entries queued.
    do_reset();
    imem_ack = 1'b1;
    repeat (3) tick();
    check("x_pre_val", {31'd0, if_valid}, 32'd1);
    imem_ack = 1'b0;
    reset    = 1'b1;
    tick();
    check("x_req", {31'd0, imem_req}, 32'd0);
    check("x_val", {31'd0, if_valid}, 32'd0);
    reset    = 1'b0;
    imem_ack = 1'b1;
    tick();
    check("x_restart_addr", {22'd0, imem_addr}, 32'd0);
    check("x_idle_ack_ign", {31'd0, if_valid}, 32'd0);
    tick();
    check("x_restart_ir", if_ir, 32'hA000_0000);

    // pc wraps modulo 2^32; address truncates to 10 bits.
    do_reset();
    imem_ack    = 1'b1;
    id_ready    = 1'b1;
    redirect    = 1'b1;
    redirect_pc = 32'hFFFF_FFFF;
    tick();
    redirect = 1'b0;
    tick();
    check("w_addr", {22'd0, imem_addr}, 32'h3FF);
    tick();
    check("w_ir",   if_ir, 32'hA000_03FF);
    check("w_npc",  if_npc, 32'h0);
    check("w_next", {22'd0, imem_addr}, 32'h0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
